// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: oversampled deserialiser that decodes ASCII '0'..'3'
// into a 2-bit opcode held under a valid/ready handshake.
module uart_cmd_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9_600,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       ready,
    output logic [1:0] opcode,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       overrun
);

    localparam int DIV = CLK_HZ / (BAUD * OVS);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] SCNT_MID  = SW'(OVS / 2 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BRK   = 3'd4;

    logic          rx_meta_q, rx_meta_d;
    logic          rxs_q, rxs_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [1:0]    opcode_q, opcode_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          cmd_err_q, cmd_err_d;
    logic          overrun_q, overrun_d;
    logic          tick_s;

    function automatic logic is_cmd_byte(input logic [7:0] b);
        return (b[7:2] == 6'b001100);
    endfunction

    // Next-state logic: synchroniser, tick divider, frame FSM and command decode
    always_comb begin
        rx_meta_d   = RxD;
        rxs_d       = rx_meta_q;
        tcnt_d      = tcnt_q;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        state_d     = state_q;
        sh_d        = sh_q;
        opcode_d    = opcode_q;
        // An accepted command drops unless a new decode reloads it below
        cmd_valid_d = cmd_valid_q & ~ready;
        frame_err_d = 1'b0;
        cmd_err_d   = 1'b0;
        overrun_d   = 1'b0;
        tick_s      = 1'b0;

        if (state_q != S_IDLE) begin
            if (tcnt_q == TCNT_LAST) begin
                tcnt_d = {TW{1'b0}};
                tick_s = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end else begin
            tcnt_d = {TW{1'b0}};
        end

        case (state_q)
            S_IDLE: begin
                scnt_d = {SW{1'b0}};
                bcnt_d = 3'd0;
                if (!rxs_q) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    if (scnt_q == SCNT_MID) begin
                        scnt_d = {SW{1'b0}};
                        if (rxs_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end else begin
                    scnt_d = scnt_q;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = {SW{1'b0}};
                        sh_d   = {rxs_q, sh_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end else begin
                    scnt_d = scnt_q;
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = {SW{1'b0}};
                        if (rxs_q) begin
                            state_d = S_IDLE;
                            // A command being accepted this cycle frees the slot
                            if (is_cmd_byte(sh_q)) begin
                                if (!cmd_valid_q || ready) begin
                                    opcode_d    = sh_q[1:0];
                                    cmd_valid_d = 1'b1;
                                end else begin
                                    overrun_d = 1'b1;
                                end
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BRK;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end else begin
                    scnt_d = scnt_q;
                end
            end
            S_BRK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BRK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            tcnt_q      <= {TW{1'b0}};
            scnt_q      <= {SW{1'b0}};
            bcnt_q      <= 3'd0;
            state_q     <= S_IDLE;
            sh_q        <= 8'h00;
            opcode_q    <= 2'd0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            tcnt_q      <= tcnt_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            state_q     <= state_d;
            sh_q        <= sh_d;
            opcode_q    <= opcode_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            cmd_err_q   <= cmd_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign opcode    = opcode_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_err   = cmd_err_q;
    assign overrun   = overrun_q;

endmodule
